// File: rtl/ifetch_stage.sv
// ifetch_stage -- instruction fetch stage feeding the decoder.
//
// Owns the fetch PC and issues word fetches over a req/ready + rvalid
// interface. Memory responses return in request order and land in a
// DEPTH-entry in-order queue. The head entry goes to the decoder over a
// valid/ready handshake. A redirect flushes the queue and counts any fetches
// still in flight, so that their late responses are dropped.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   DEPTH     queue entries and max outstanding fetches (power of 2, >= 2)
//
// Ports
//   clk, rst                           clock (rising edge), async active-high reset
//   redirect_valid, redirect_pc        flush and restart fetch at redirect_pc
//   imem_req, imem_addr                fetch request and word address
//   imem_ready                         memory accepts the request this cycle
//   imem_rvalid, imem_rdata            in-order response from memory
//   if_valid, if_instr, if_pc, if_excp head entry presented to the decoder
//   id_ready                           decoder consumes the head this cycle
//
// Optional feature, macro IFETCH_MISALIGN_TRAP_EN:
//   A misaligned redirect halts fetch. It also enqueues a single trap entry
//   {pc=redirect_pc, instr=32'h13, excp=1}. The next aligned redirect (or
//   reset) resumes fetch. Without the macro, redirect_pc[1:0] is ignored and
//   if_excp is tied to 0.

module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_excp,
   input  logic        id_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   // Discard can exceed DEPTH after back-to-back redirects, so it gets more room.
   localparam int unsigned DW = 16;
   localparam logic [CW-1:0] FULL       = CW'(DEPTH);
   localparam logic [31:0]   TRAP_INSTR = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   // count = all allocated entries (filled + awaiting response) = slots used
   logic [CW-1:0] count_q, count_d;
   // outst = allocated entries still awaiting their response (always the youngest)
   logic [CW-1:0] outst_q, outst_d;
   logic [DW-1:0] disc_q, disc_d;
   logic [DW-1:0] pending;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic          halted;
   logic          trap_hit;
   logic          issue, pop, fill_en, drop;
   logic [AW-1:0] fill_idx;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic          halt_q, halt_d;
   logic          excp_mem [DEPTH];
   assign halted   = halt_q;
   assign trap_hit = redirect_valid & (|redirect_pc[1:0]);
`else
   assign halted   = 1'b0;
   // Low redirect bits carry no meaning in this build.
   assign trap_hit = 1'b0 & (|redirect_pc[1:0]);
`endif

   assign imem_req  = ~rst & (count_q < FULL) & ~redirect_valid & ~halted;
   assign imem_addr = fetch_pc_q;

   // Entries fill in order, so the head is filled whenever any entry is.
   assign if_valid  = (count_q != outst_q);
   assign if_pc     = if_valid ? pc_mem[head_q]    : '0;
   assign if_instr  = if_valid ? instr_mem[head_q] : '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign if_excp   = if_valid & excp_mem[head_q];
`else
   assign if_excp   = 1'b0;
`endif

   assign issue    = imem_req & imem_ready;
   assign pop      = if_valid & id_ready & ~redirect_valid;
   assign drop     = imem_rvalid & ~redirect_valid & (disc_q != '0);
   assign fill_en  = imem_rvalid & ~redirect_valid & (disc_q == '0) & (outst_q != '0);
   // Oldest unfilled entry sits outst places behind the tail.
   assign fill_idx = tail_q - outst_q[AW-1:0];
   assign pending  = disc_q + DW'(outst_q);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      outst_d    = outst_q;
      disc_d     = disc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halt_d     = halt_q;
`endif
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         head_d     = '0;
         outst_d    = '0;
         // A response arriving now retires one pending fetch before the rest
         // are turned into discards.
         disc_d     = pending - DW'(imem_rvalid && (pending != '0));
         if (trap_hit) begin
            tail_d  = AW'(1);
            count_d = CW'(1);
         end else begin
            tail_d  = '0;
            count_d = '0;
         end
`ifdef IFETCH_MISALIGN_TRAP_EN
         halt_d     = trap_hit;
`endif
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
         head_d  = head_q + AW'(pop);
         tail_d  = tail_q + AW'(issue);
         count_d = count_q + CW'(issue) - CW'(pop);
         outst_d = outst_q + CW'(issue) - CW'(fill_en);
         disc_d  = disc_q - DW'(drop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         disc_q     <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         halt_q     <= 1'b0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         halt_q     <= halt_d;
`endif
      end
   end

   // Entry storage. Issue and fill never target the same slot: a fill needs
   // outst>0, so fill_idx==tail only when the queue is full and no issue occurs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            excp_mem[i]  <= 1'b0;
`endif
         end
      end else if (redirect_valid) begin
         if (trap_hit) begin
            pc_mem[0]    <= redirect_pc;
            instr_mem[0] <= TRAP_INSTR;
`ifdef IFETCH_MISALIGN_TRAP_EN
            excp_mem[0]  <= 1'b1;
`endif
         end
      end else begin
         if (issue) begin
            pc_mem[tail_q] <= fetch_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
            excp_mem[tail_q] <= 1'b0;
`endif
         end
         if (fill_en) instr_mem[fill_idx] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Testbench for ifetch_stage: an in-order memory model with random latency
// drives the DUT. A queue-based reference model of the fetch stage predicts
// every output on every cycle.

module tb_ifetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned DEP    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_excp;
   logic        id_ready;

   ifetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_excp(if_excp),
      .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          excp;
      bit          filled;
   } ent_t;
   ent_t        mq[$];
   int unsigned m_out, m_disc;
   logic [31:0] m_pc;
   bit          m_halt;

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;
   mreq_t       memq[$];
   int unsigned cyc = 0, last_due = 0;
   int unsigned lat_min = 1, lat_max = 1;

   logic [31:0] popped[$];
   logic [31:0] issued[$];

   int n_chk = 0;
   int n_bad = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      #1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_addr",  imem_addr,     RST_PC);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr,      32'd0);
      chk("rst_pc",    if_pc,         32'd0);
      chk("rst_excp",  32'(if_excp),  32'd0);
      mq.delete(); memq.delete();
      m_out = 0; m_disc = 0; m_pc = RST_PC; m_halt = 0;
      last_due = cyc;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // One clock cycle: apply inputs, compare against the model, advance both.
   task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit idr);
      bit          e_req, e_valid;
      logic [31:0] e_pc, e_instr;
      bit          e_excp;
      int unsigned pend, idx, lat, due;
      redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy; id_ready = idr;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rvalid = 1'b1; imem_rdata = word_of(memq[0].addr);
      end else begin
         imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      #1;
      e_req   = !rv && !m_halt && (mq.size() < DEP);
      e_valid = (mq.size() > 0) && mq[0].filled;
      e_pc    = e_valid ? mq[0].pc    : 32'd0;
      e_instr = e_valid ? mq[0].instr : 32'd0;
      e_excp  = e_valid ? mq[0].excp  : 1'b0;
      chk("req",   32'(imem_req), 32'(e_req));
      chk("addr",  imem_addr,     m_pc);
      chk("valid", 32'(if_valid), 32'(e_valid));
      chk("pc",    if_pc,         e_pc);
      chk("instr", if_instr,      e_instr);
      chk("excp",  32'(if_excp),  32'(e_excp));
      if (e_valid && idr && !rv) popped.push_back(e_pc);
      if (rv) begin
         pend = m_disc + m_out;
         if (imem_rvalid && pend > 0) pend--;
         m_disc = pend; m_out = 0; mq.delete();
         m_pc = {rpc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_TRAP_EN
         m_halt = (rpc[1:0] != 2'b00);
         if (m_halt) mq.push_back('{pc: rpc, instr: 32'h13, excp: 1'b1, filled: 1'b1});
`endif
      end else begin
         if (imem_rvalid) begin
            if (m_disc > 0) m_disc--;
            else if (m_out > 0) begin
               idx = mq.size() - m_out;
               mq[idx].instr  = word_of(mq[idx].pc);
               mq[idx].filled = 1'b1;
               m_out--;
            end
         end
         if (e_valid && idr) void'(mq.pop_front());
         if (e_req && rdy) begin
            mq.push_back('{pc: m_pc, instr: 32'd0, excp: 1'b0, filled: 1'b0});
            m_out++;
            m_pc = m_pc + 32'd4;
         end
      end
      if (imem_rvalid) void'(memq.pop_front());
      if (imem_req && rdy) begin
         issued.push_back(imem_addr);
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         memq.push_back('{addr: imem_addr, due: due});
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: streaming fetch with a 1-cycle memory
      do_reset(); popped.delete();
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1);
      for (int i = 0; i < 4; i++)
         chk("t1_order", (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));

      // 2: decoder stall fills the queue, then drains in order
      do_reset(); popped.delete(); issued.delete();
      for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
      chk("t2_issued", 32'(issued.size()), 32'(DEP));
      chk("t2_hold",   if_pc, 32'd0);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 1);
      for (int i = 0; i < 3; i++)
         chk("t2_order", (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));

      // 3: redirect with two fetches outstanding
      do_reset(); lat_min = 3; lat_max = 3;
      step(0, '0, 1, 1); step(0, '0, 1, 1);
      popped.delete();
      step(1, 32'h100, 1, 1);
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
      chk("t3_first", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h100);

      // 4: PC wraps past the top of the address space
      do_reset(); step(1, 32'hFFFF_FFF8, 1, 1); issued.delete();
      for (int i = 0; i < 6; i++) step(0, '0, 1, 1);
      chk("t4_a0", (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      chk("t4_a1", (issued.size() > 1) ? issued[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("t4_a2", (issued.size() > 2) ? issued[2] : 32'hDEAD_BEEF, 32'h0000_0000);

      // 5: redirect, response and pop in one cycle
      do_reset();
      step(0, '0, 1, 1); step(0, '0, 1, 1);
      chk("t5_pre", {30'd0, imem_rvalid, if_valid}, 32'd3);
      step(1, 32'h300, 1, 1);
      chk("t5_addr",  imem_addr,     32'h300);
      chk("t5_valid", 32'(if_valid), 32'd0);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 1);

`ifdef IFETCH_MISALIGN_TRAP_EN
      // 6: misaligned redirect traps and halts until an aligned redirect
      do_reset(); step(1, 32'h102, 1, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      chk("t6_pc",    if_pc,         32'h102);
      chk("t6_instr", if_instr,      32'h13);
      chk("t6_excp",  32'(if_excp),  32'd1);
      chk("t6_req",   32'(imem_req), 32'd0);
      issued.delete();
      step(1, 32'h200, 1, 1);
      for (int i = 0; i < 4; i++) step(0, '0, 1, 1);
      chk("t6_resume", (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF, 32'h200);
`endif

      // random traffic, variable memory latency, one mid-run reset
      do_reset(); lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] rpc;
         if (i == 2000) do_reset();
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                        : $urandom;
         step(($urandom_range(15) == 0), rpc, ($urandom_range(3) != 0),
              ($urandom_range(2) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
